pc_redirect_unit: RTL and testbench



---
 rtl/pc_redirect_unit.sv | 125 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Program-counter owner for the fetch stage: sequential advance, EX-stage branch/JAL redirects,
// and the IF/ID + ID/EX flush window. Optional misaligned-target trap under `MISALIGN_TRAP_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Branch_Target,
    input  logic        Branch_Taken,
    input  logic [6:0]  Ex_Opcode,
    input  logic        Stall,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ready,
    output logic [31:0] PC_out,
    output logic        Flush_IF_ID,
    output logic        Flush_ID_EX,
    output logic        Misalign_trap
);

    localparam logic [6:0] RV32_BRANCH = 7'b1100011;
    localparam logic [6:0] RV32_JAL    = 7'b1101111;
    localparam logic [2:0] FLUSH_LAST  = 3'(FLUSH_CYCLES - 1);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        RUN,
        PEND,
        FLUSH
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_target_q;
    logic [2:0]  flush_cnt_q;

    logic        redirect;
    logic        accept;
    logic [31:0] accept_target;

    function automatic logic is_misaligned(input logic [31:0] target);
        return TRAP_EN && (target[1:0] != 2'b00);
    endfunction

    // Misaligned targets either trap or have their low bits dropped.
    function automatic logic [31:0] resolve_target(input logic [31:0] target);
        return is_misaligned(target) ? TRAP_VECTOR : {target[31:2], 2'b00};
    endfunction

    assign redirect = ((Ex_Opcode == RV32_BRANCH) && Branch_Taken) || (Ex_Opcode == RV32_JAL);

    // A redirect is applied on the edge where memory accepts the request that carries it.
    assign accept        = Imem_ready && (((state_q == RUN) && redirect) || (state_q == PEND));
    assign accept_target = (state_q == PEND) ? pend_target_q : Branch_Target;

    assign Imem_req    = reset_n && !((state_q == RUN) && Stall && !redirect);
    assign Imem_addr   = pc_q;
    assign PC_out      = pc_q;
    assign Flush_IF_ID = reset_n && ((state_q != RUN) || redirect);
    assign Flush_ID_EX = Flush_IF_ID;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_VECTOR;
            // NOTE: the latched target is reset too so a reset mid-PEND can never leak a stale address.
            pend_target_q <= 32'h0;
            flush_cnt_q   <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            if (accept) begin
                pc_q        <= resolve_target(accept_target);
                state_q     <= FLUSH;
                flush_cnt_q <= FLUSH_LAST;
            end else begin
                case (state_q)
                    RUN: begin
                        if (redirect) begin
                            pend_target_q <= Branch_Target;
                            state_q       <= PEND;
                        end else if (Imem_ready && !Stall) begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                    PEND: begin
                        state_q <= PEND;
                    end
                    FLUSH: begin
                        if (Imem_ready) begin
                            pc_q <= pc_q + 32'd4;
                        end
                        if (flush_cnt_q == 3'd0) begin
                            state_q <= RUN;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - 3'd1;
                        end
                    end
                    default: begin
                        state_q <= RUN;
                    end
                endcase
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Misalign_trap <= 1'b0;
        end else begin
            Misalign_trap <= accept && is_misaligned(accept_target);
        end
    end
`else
    assign Misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: sequential fetch, redirects, PEND handshake hold,
// stall priority, PC wrap, misaligned targets and reset in the middle of PEND/FLUSH.
module tb_pc_redirect_unit;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ALU    = 7'b0010011;

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EXP = 1'b1;
`else
    localparam logic TRAP_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Branch_Target;
    logic        Branch_Taken;
    logic [6:0]  Ex_Opcode;
    logic        Stall;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ready;
    logic [31:0] PC_out;
    logic        Flush_IF_ID;
    logic        Flush_ID_EX;
    logic        Misalign_trap;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .FLUSH_CYCLES(2),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Branch_Target(Branch_Target),
        .Branch_Taken (Branch_Taken),
        .Ex_Opcode    (Ex_Opcode),
        .Stall        (Stall),
        .Imem_req     (Imem_req),
        .Imem_addr    (Imem_addr),
        .Imem_ready   (Imem_ready),
        .PC_out       (PC_out),
        .Flush_IF_ID  (Flush_IF_ID),
        .Flush_ID_EX  (Flush_ID_EX),
        .Misalign_trap(Misalign_trap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic req,
                              input logic flush);
        check({tag, "/pc"}, PC_out, pc);
        check({tag, "/addr"}, Imem_addr, pc);
        check({tag, "/req"}, {31'd0, Imem_req}, {31'd0, req});
        check({tag, "/flush_if_id"}, {31'd0, Flush_IF_ID}, {31'd0, flush});
        check({tag, "/flush_id_ex"}, {31'd0, Flush_ID_EX}, {31'd0, flush});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        Branch_Target = 32'h0;
        Branch_Taken  = 1'b0;
        Ex_Opcode     = OP_ALU;
        Stall         = 1'b0;
        Imem_ready    = 1'b1;

        #12;
        expect_out("reset", 32'h0, 1'b0, 1'b0);
        check("reset/trap", {31'd0, Misalign_trap}, 32'd0);
        reset_n = 1'b1;
        #1;
        expect_out("post_reset", 32'h0, 1'b1, 1'b0);

        for (int i = 1; i <= 8; i++) begin
            tick;
            expect_out("seq", 32'(i * 4), 1'b1, 1'b0);
        end

        // Taken branch at 0x20 to 0x80
        Ex_Opcode = OP_BRANCH; Branch_Taken = 1'b1; Branch_Target = 32'h80;
        #1;
        expect_out("br_detect", 32'h20, 1'b1, 1'b1);
        tick;
        Ex_Opcode = OP_ALU; Branch_Taken = 1'b0;
        #1;
        expect_out("br_f1", 32'h80, 1'b1, 1'b1);
        tick;
        expect_out("br_f2", 32'h84, 1'b1, 1'b1);
        tick;
        expect_out("br_done", 32'h88, 1'b1, 1'b0);

        // Not-taken branch, then JAL with Branch_Taken=0
        Ex_Opcode = OP_BRANCH; Branch_Taken = 1'b0; Branch_Target = 32'h80;
        #1;
        expect_out("nt_detect", 32'h88, 1'b1, 1'b0);
        tick;
        expect_out("nt_seq", 32'h8C, 1'b1, 1'b0);
        Ex_Opcode = OP_JAL; Branch_Target = 32'h40;
        #1;
        expect_out("jal_detect", 32'h8C, 1'b1, 1'b1);
        tick;
        Ex_Opcode = OP_ALU;
        #1;
        expect_out("jal_f1", 32'h40, 1'b1, 1'b1);
        tick;
        expect_out("jal_f2", 32'h44, 1'b1, 1'b1);
        tick;
        expect_out("jal_done", 32'h48, 1'b1, 1'b0);

        // JAL to 0x200 with memory not ready for 3 cycles; second JAL to 0x300 ignored
        Ex_Opcode = OP_JAL; Branch_Target = 32'h200; Imem_ready = 1'b0;
        #1;
        expect_out("pend_detect", 32'h48, 1'b1, 1'b1);
        tick;
        Branch_Target = 32'h300;
        #1;
        expect_out("pend1", 32'h48, 1'b1, 1'b1);
        tick;
        expect_out("pend2", 32'h48, 1'b1, 1'b1);
        Imem_ready = 1'b1;
        tick;
        expect_out("pend_acc", 32'h200, 1'b1, 1'b1);
        tick;
        expect_out("pend_f2", 32'h204, 1'b1, 1'b1);
        tick;
        Ex_Opcode = OP_ALU;
        #1;
        expect_out("pend_done", 32'h208, 1'b1, 1'b0);

        // Stall together with a taken branch: redirect wins, then stall holds in RUN
        Stall = 1'b1; Ex_Opcode = OP_BRANCH; Branch_Taken = 1'b1; Branch_Target = 32'h44;
        #1;
        expect_out("stall_br", 32'h208, 1'b1, 1'b1);
        tick;
        Ex_Opcode = OP_ALU; Branch_Taken = 1'b0;
        #1;
        expect_out("stall_br_f1", 32'h44, 1'b1, 1'b1);
        tick;
        expect_out("stall_br_f2", 32'h48, 1'b1, 1'b1);
        tick;
        expect_out("stall_hold0", 32'h4C, 1'b0, 1'b0);
        tick;
        expect_out("stall_hold1", 32'h4C, 1'b0, 1'b0);
        Stall = 1'b0;
        #1;
        expect_out("stall_release", 32'h4C, 1'b1, 1'b0);

        // PC wrap from 0xFFFFFFFC
        Ex_Opcode = OP_JAL; Branch_Target = 32'hFFFF_FFFC;
        tick;
        Ex_Opcode = OP_ALU;
        #1;
        expect_out("wrap_a", 32'hFFFF_FFFC, 1'b1, 1'b1);
        tick;
        expect_out("wrap_b", 32'h0, 1'b1, 1'b1);
        tick;
        expect_out("wrap_c", 32'h4, 1'b1, 1'b0);

        // Misaligned JAL target: 0x100 in both builds, trap pulse only when enabled
        Ex_Opcode = OP_JAL; Branch_Target = 32'h102;
        tick;
        Ex_Opcode = OP_ALU;
        #1;
        expect_out("mis", 32'h100, 1'b1, 1'b1);
        check("mis/trap", {31'd0, Misalign_trap}, {31'd0, TRAP_EXP});
        tick;
        expect_out("mis_f2", 32'h104, 1'b1, 1'b1);
        check("mis/trap_end", {31'd0, Misalign_trap}, 32'd0);
        tick;
        expect_out("mis_done", 32'h108, 1'b1, 1'b0);

        // Reset asserted mid-FLUSH
        Ex_Opcode = OP_JAL; Branch_Target = 32'h500;
        tick;
        Ex_Opcode = OP_ALU;
        #1;
        expect_out("rf_flush", 32'h500, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        expect_out("rf_reset", 32'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1;
        expect_out("rf_release", 32'h0, 1'b1, 1'b0);
        tick;
        expect_out("rf_run", 32'h4, 1'b1, 1'b0);

        // Reset asserted mid-PEND: latched target must be discarded
        Imem_ready = 1'b0; Ex_Opcode = OP_JAL; Branch_Target = 32'h600;
        tick;
        #1;
        expect_out("rp_pend", 32'h4, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        expect_out("rp_reset", 32'h0, 1'b0, 1'b0);
        reset_n = 1'b1; Ex_Opcode = OP_ALU; Imem_ready = 1'b1;
        #1;
        expect_out("rp_release", 32'h0, 1'b1, 1'b0);
        tick;
        expect_out("rp_run0", 32'h4, 1'b1, 1'b0);
        tick;
        expect_out("rp_run1", 32'h8, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
